// File: rtl/i_cache_nway.sv
// i_cache_nway: N-way set-associative read-only instruction cache.
// Hits answer one cycle after the address is accepted. Misses stall the
// front end while the victim line is refilled word by word. Replacement
// is round-robin per set. A flush invalidates every line.
//
// Handshake on every channel (addr, order, load_addr, load_order): a word
// moves when valid && !busy at a rising clock edge. The sender holds valid
// and data stable until that edge. The receiver may raise or drop busy at
// any time.

// Single-port synchronous RAM: q shows mem[addr] one cycle after addr.
module sram_wrapper #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] q
);
    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    // Write port and registered read port share one address.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        q <= mem[addr];
    end
endmodule

module i_cache_nway #(
    parameter int LABEL_WIDTH     = 24,
    parameter int GROUP_WIDTH     = 2,
    parameter int BIASE_WIDTH     = 6,
    parameter int DATA_BYTE_WIDTH = 2,
    parameter int GROUP_LINK      = 4,
    parameter int CNT_WIDTH       = 16,
    localparam int A      = LABEL_WIDTH + GROUP_WIDTH + BIASE_WIDTH,
    localparam int W      = 8 * (2 ** DATA_BYTE_WIDTH),
    localparam int OFF_W  = BIASE_WIDTH - DATA_BYTE_WIDTH,
    localparam int SETS   = 2 ** GROUP_WIDTH,
    localparam int RAM_AW = GROUP_WIDTH + OFF_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    // fetch address
    input  logic                 addr_valid,
    output logic                 addr_busy,
    input  logic [A-1:0]         addr_data,
    // instruction word
    output logic                 order_valid,
    input  logic                 order_busy,
    output logic [W-1:0]         order_data,
    // refill word address
    output logic                 load_addr_valid,
    input  logic                 load_addr_busy,
    output logic [A-1:0]         load_addr_data,
    // refill data
    input  logic                 load_order_valid,
    output logic                 load_order_busy,
    input  logic [W-1:0]         load_order_data,
    // flush and statistics
    input  logic                 flush_req,
    output logic                 flush_busy,
    output logic [CNT_WIDTH-1:0] hit_count,
    output logic [CNT_WIDTH-1:0] miss_count
);

    // state_q is the observable FSM state for checkers.
    typedef enum logic [1:0] {
        NORM  = 2'd0,
        FILL  = 2'd1,
        RETU  = 2'd2,
        FLUSH = 2'd3
    } state_t;

    state_t state_q;
    state_t state_d;

    // Tag store, valid bits and one-hot round-robin pointers, all flops.
    logic [LABEL_WIDTH-1:0] tag_q   [SETS][GROUP_LINK];
    logic [GROUP_LINK-1:0]  valid_q [SETS];
    logic [GROUP_LINK-1:0]  rr_q    [SETS];

    logic [A-1:0]          req_addr_q;
    logic [GROUP_LINK-1:0] victim_q;
    logic [GROUP_LINK-1:0] sel_way_q;
    logic [OFF_W-1:0]      issue_cnt;
    logic [OFF_W-1:0]      save_cnt;

    // Field views of the incoming and the latched address.
    logic [LABEL_WIDTH-1:0] a_tag;
    logic [GROUP_WIDTH-1:0] a_set;
    logic [OFF_W-1:0]       a_word;
    logic [LABEL_WIDTH-1:0] r_tag;
    logic [GROUP_WIDTH-1:0] r_set;
    logic [OFF_W-1:0]       r_word;

    assign a_tag  = addr_data[A-1 -: LABEL_WIDTH];
    assign a_set  = addr_data[BIASE_WIDTH +: GROUP_WIDTH];
    assign a_word = addr_data[DATA_BYTE_WIDTH +: OFF_W];
    assign r_tag  = req_addr_q[A-1 -: LABEL_WIDTH];
    assign r_set  = req_addr_q[BIASE_WIDTH +: GROUP_WIDTH];
    assign r_word = req_addr_q[DATA_BYTE_WIDTH +: OFF_W];

    // Byte-offset bits never select anything: fetches are word aligned.
    logic unused_bits;
    assign unused_bits = ^{addr_data[DATA_BYTE_WIDTH-1:0],
                           req_addr_q[DATA_BYTE_WIDTH-1:0]};

    logic [GROUP_LINK-1:0] hit_vec;
    logic                  any_hit;
    logic                  addr_accept;
    logic                  order_xfer;
    logic                  la_xfer;
    logic                  lo_xfer;
    logic                  last_word;

    logic [RAM_AW-1:0]     ram_addr;
    logic [GROUP_LINK-1:0] ram_we;
    logic [W-1:0]          ram_q [GROUP_LINK];

    // Handshake qualifiers. A new fetch is taken only when the output
    // register is free or is emptying in this same cycle.
    assign addr_busy       = (state_q != NORM) || flush_req || (order_valid && order_busy);
    assign flush_busy      = (state_q != NORM);
    assign load_order_busy = (state_q != FILL);
    assign addr_accept     = addr_valid && !addr_busy;
    assign order_xfer      = order_valid && !order_busy;
    assign la_xfer         = load_addr_valid && !load_addr_busy;
    assign lo_xfer         = load_order_valid && !load_order_busy;
    assign last_word       = lo_xfer && (&save_cnt);
    assign any_hit         = |hit_vec;

    assign load_addr_data  = {req_addr_q[A-1:BIASE_WIDTH], issue_cnt,
                              {DATA_BYTE_WIDTH{1'b0}}};

    // Tag compare of the addressed set against the incoming fetch address.
    always_comb begin
        hit_vec = '0;
        for (int w = 0; w < GROUP_LINK; w++) begin
            hit_vec[w] = valid_q[a_set][w] && (tag_q[a_set][w] == a_tag);
        end
    end

    // Shared RAM address: refill slot while filling, new fetch on accept,
    // otherwise the latched request so order_data holds while stalled.
    always_comb begin
        ram_addr = {r_set, r_word};
        if (state_q == FILL) begin
            ram_addr = {r_set, save_cnt};
        end else if (state_q == NORM && addr_accept) begin
            ram_addr = {a_set, a_word};
        end
    end

    // Only the victim way takes refill writes.
    always_comb begin
        ram_we = '0;
        for (int w = 0; w < GROUP_LINK; w++) begin
            ram_we[w] = (state_q == FILL) && lo_xfer && victim_q[w];
        end
    end

    // One data RAM per way.
    for (genvar g = 0; g < GROUP_LINK; g++) begin : g_way
        sram_wrapper #(
            .ADDR_WIDTH (RAM_AW),
            .DATA_WIDTH (W)
        ) u_ram (
            .clk   (clk),
            .we    (ram_we[g]),
            .addr  (ram_addr),
            .wdata (load_order_data),
            .q     (ram_q[g])
        );
    end

    // Output word comes from the selected way and reads zero when idle.
    always_comb begin
        order_data = '0;
        for (int w = 0; w < GROUP_LINK; w++) begin
            if (order_valid && sel_way_q[w]) begin
                order_data = order_data | ram_q[w];
            end
        end
    end

    // Next-state logic; a flush request wins because it blocks accepts.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            NORM: begin
                if (flush_req) begin
                    state_d = FLUSH;
                end else if (addr_accept && !any_hit) begin
                    state_d = FILL;
                end
            end
            FILL: begin
                if (last_word) begin
                    state_d = RETU;
                end
            end
            RETU:    state_d = NORM;
            FLUSH:   state_d = NORM;
            default: state_d = NORM;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= NORM;
        end else begin
            state_q <= state_d;
        end
    end

    // Latch the accepted request and its set's current victim way.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_addr_q <= '0;
            victim_q   <= '0;
        end else if (state_q == NORM && addr_accept) begin
            req_addr_q <= addr_data;
            victim_q   <= rr_q[a_set];
        end
    end

    // Tags, valid bits and pointers: install the line on return, clear on flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                rr_q[s]    <= GROUP_LINK'(1);
                for (int w = 0; w < GROUP_LINK; w++) begin
                    tag_q[s][w] <= '0;
                end
            end
        end else if (state_q == RETU) begin
            for (int w = 0; w < GROUP_LINK; w++) begin
                if (victim_q[w]) begin
                    tag_q[r_set][w]   <= r_tag;
                    valid_q[r_set][w] <= 1'b1;
                end
            end
            rr_q[r_set] <= {rr_q[r_set][GROUP_LINK-2:0], rr_q[r_set][GROUP_LINK-1]};
        end else if (state_q == FLUSH) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                rr_q[s]    <= GROUP_LINK'(1);
            end
        end
    end

    // Refill sequencing: issue N word addresses, count N returned words.
    // Both counters wrap back to zero after the last word of a line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_addr_valid <= 1'b0;
            issue_cnt       <= '0;
            save_cnt        <= '0;
        end else if (state_q == NORM && addr_accept && !any_hit) begin
            load_addr_valid <= 1'b1;
            issue_cnt       <= '0;
            save_cnt        <= '0;
        end else if (state_q == FILL) begin
            if (la_xfer) begin
                issue_cnt <= issue_cnt + 1'b1;
                if (&issue_cnt) begin
                    load_addr_valid <= 1'b0;
                end
            end
            if (lo_xfer) begin
                save_cnt <= save_cnt + 1'b1;
            end
        end
    end

    // Output valid and way select: set by a hit or a returning miss,
    // cleared once the word has been taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            order_valid <= 1'b0;
            sel_way_q   <= '0;
        end else if (state_q == NORM && addr_accept && any_hit) begin
            order_valid <= 1'b1;
            sel_way_q   <= hit_vec;
        end else if (state_q == RETU) begin
            order_valid <= 1'b1;
            sel_way_q   <= victim_q;
        end else if (order_xfer) begin
            order_valid <= 1'b0;
        end
    end

    // Saturating hit/miss statistics, counted at address accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (state_q == NORM && addr_accept) begin
            if (any_hit) begin
                if (hit_count != '1) begin
                    hit_count <= hit_count + 1'b1;
                end
            end else begin
                if (miss_count != '1) begin
                    miss_count <= miss_count + 1'b1;
                end
            end
        end
    end

    // A set must never hold the same tag in two ways.
    always_ff @(posedge clk) begin
        if (state_q == NORM && addr_valid) begin
            assert ($onehot0(hit_vec));
        end
    end

endmodule

// File: tb/tb_i_cache_nway.sv
// tb_i_cache_nway: directed and randomized fetch sequences against a
// behavioural cache model; a memory responder returns word = byte address.
module tb_i_cache_nway;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        addr_valid;
    logic        addr_busy;
    logic [31:0] addr_data;
    logic        order_valid;
    logic        order_busy;
    logic [31:0] order_data;
    logic        load_addr_valid;
    logic        load_addr_busy;
    logic [31:0] load_addr_data;
    logic        load_order_valid;
    logic        load_order_busy;
    logic [31:0] load_order_data;
    logic        flush_req;
    logic        flush_busy;
    logic [15:0] hit_count;
    logic [15:0] miss_count;

    i_cache_nway dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .addr_valid       (addr_valid),
        .addr_busy        (addr_busy),
        .addr_data        (addr_data),
        .order_valid      (order_valid),
        .order_busy       (order_busy),
        .order_data       (order_data),
        .load_addr_valid  (load_addr_valid),
        .load_addr_busy   (load_addr_busy),
        .load_addr_data   (load_addr_data),
        .load_order_valid (load_order_valid),
        .load_order_busy  (load_order_busy),
        .load_order_data  (load_order_data),
        .flush_req        (flush_req),
        .flush_busy       (flush_busy),
        .hit_count        (hit_count),
        .miss_count       (miss_count)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [23:0] m_tag [4][4];
    bit          m_val [4][4];
    int          m_ptr [4];
    int          m_hits;
    int          m_miss;

    function automatic void model_flush();
        for (int s = 0; s < 4; s++) begin
            m_ptr[s] = 0;
            for (int w = 0; w < 4; w++) m_val[s][w] = 0;
        end
    endfunction

    function automatic void model_reset();
        model_flush();
        m_hits = 0;
        m_miss = 0;
    endfunction

    // Returns 1 on hit; on a miss installs the line in the set's next way.
    function automatic bit model_access(input logic [31:0] a);
        int s;
        logic [23:0] t;
        s = int'(a[7:6]);
        t = a[31:8];
        for (int w = 0; w < 4; w++) begin
            if (m_val[s][w] && m_tag[s][w] == t) begin
                if (m_hits < 65535) m_hits++;
                return 1'b1;
            end
        end
        m_tag[s][m_ptr[s]] = t;
        m_val[s][m_ptr[s]] = 1'b1;
        m_ptr[s] = (m_ptr[s] + 1) % 4;
        if (m_miss < 65535) m_miss++;
        return 1'b0;
    endfunction

    // ---------------- memory responder ----------------
    logic [31:0] pend_q   [$];
    logic [31:0] issued_q [$];
    int cyc       = 0;
    int acc_cyc   = 0;
    int last_cyc  = 0;
    int rf_words  = 0;
    bit ld_xfer   = 0;
    bit mem_stall_en = 0;

    // Observe transfers at the active edge.
    always @(posedge clk) begin
        cyc     <= cyc + 1;
        ld_xfer <= load_order_valid && !load_order_busy;
        if (addr_valid && !addr_busy) acc_cyc <= cyc;
        if (!rst_n) begin
            pend_q.delete();
        end else begin
            if (load_addr_valid && !load_addr_busy) begin
                pend_q.push_back(load_addr_data);
                issued_q.push_back(load_addr_data);
            end
            if (load_order_valid && !load_order_busy && pend_q.size() > 0) begin
                void'(pend_q.pop_front());
                last_cyc <= cyc;
                rf_words <= rf_words + 1;
            end
        end
    end

    // Drive memory-side inputs on the falling edge; valid is held until taken.
    always @(negedge clk) begin
        load_addr_busy = mem_stall_en && ($urandom_range(0, 3) == 0);
        if (!rst_n) begin
            load_order_valid = 1'b0;
            load_order_data  = '0;
        end else if (!(load_order_valid && !ld_xfer)) begin
            load_order_valid = (pend_q.size() > 0) &&
                               (!mem_stall_en || $urandom_range(0, 2) != 0);
            load_order_data  = (pend_q.size() > 0) ? pend_q[0] : 32'h0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic chk_reset_vals(input string p);
        chk({p, "_order_valid"}, order_valid, 0);
        chk({p, "_load_addr_valid"}, load_addr_valid, 0);
        chk({p, "_hit_count"}, hit_count, 0);
        chk({p, "_miss_count"}, miss_count, 0);
        chk({p, "_order_data"}, order_data, 0);
        chk({p, "_addr_busy"}, addr_busy, 0);
        chk({p, "_flush_busy"}, flush_busy, 0);
        chk({p, "_load_order_busy"}, load_order_busy, 1);
    endtask

    // Called at a falling edge with the cache idle; returns at a falling edge.
    task automatic do_fetch(input logic [31:0] a, input int stall);
        bit exp_hit;
        int n;
        int iss_base;
        int bad;
        int lat;
        logic [31:0] d0;
        exp_hit  = model_access(a);
        iss_base = issued_q.size();
        addr_valid = 1'b1;
        addr_data  = a;
        order_busy = (stall > 0);
        #1;
        n = 0;
        while (addr_busy && n < 50) begin
            @(negedge clk); #1; n++;
        end
        chk("accept_wait", addr_busy, 0);
        @(negedge clk);
        addr_valid = 1'b0;
        addr_data  = $urandom;
        #1;
        chk("load_addr_start", load_addr_valid, !exp_hit);
        n = 0;
        while (!order_valid && n < 400) begin
            @(negedge clk); #1; n++;
        end
        chk("resp_valid", order_valid, 1);
        chk("resp_data", order_data, a & 32'hFFFF_FFFC);
        lat = exp_hit ? (cyc - acc_cyc) : (cyc - last_cyc);
        chk(exp_hit ? "hit_latency" : "miss_latency", lat, exp_hit ? 1 : 2);
        chk("hit_count", hit_count, m_hits);
        chk("miss_count", miss_count, m_miss);
        chk("refill_len", issued_q.size() - iss_base, exp_hit ? 0 : 16);
        bad = 0;
        for (int i = iss_base; i < issued_q.size(); i++) begin
            if (issued_q[i] !== ((a & 32'hFFFF_FFC0) + 32'((i - iss_base) * 4))) bad++;
        end
        chk("refill_seq", bad, 0);
        d0 = order_data;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk); #1;
            chk("stall_valid", order_valid, 1);
            chk("stall_data", order_data, d0);
            chk("stall_addr_busy", addr_busy, 1);
        end
        order_busy = 1'b0;
        @(negedge clk); #1;
        chk("order_clear", order_valid, 0);
    endtask

    task automatic do_flush();
        flush_req = 1'b1;
        #1;
        chk("flush_addr_busy", addr_busy, 1);
        chk("flush_busy_pre", flush_busy, 0);
        @(negedge clk);
        flush_req = 1'b0;
        #1;
        chk("flush_busy_active", flush_busy, 1);
        chk("flush_addr_busy_active", addr_busy, 1);
        @(negedge clk); #1;
        chk("flush_busy_done", flush_busy, 0);
        model_flush();
    endtask

    task automatic back_to_back();
        bit h;
        h = model_access(32'h04C);
        h = model_access(32'h050);
        addr_valid = 1'b1;
        addr_data  = 32'h04C;
        #1;
        chk("b2b_first_busy", addr_busy, 0);
        @(negedge clk);
        addr_data = 32'h050;
        #1;
        chk("b2b_first_valid", order_valid, 1);
        chk("b2b_first_data", order_data, 32'h04C);
        chk("b2b_second_busy", addr_busy, 0);
        @(negedge clk);
        addr_valid = 1'b0;
        #1;
        chk("b2b_second_valid", order_valid, 1);
        chk("b2b_second_data", order_data, 32'h050);
        chk("b2b_hit_count", hit_count, m_hits);
        @(negedge clk); #1;
        chk("b2b_clear", order_valid, 0);
    endtask

    task automatic reset_mid_fill();
        int start;
        int n;
        start = rf_words;
        addr_valid = 1'b1;
        addr_data  = 32'h840;
        #1;
        n = 0;
        while (addr_busy && n < 50) begin
            @(negedge clk); #1; n++;
        end
        @(negedge clk);
        addr_valid = 1'b0;
        n = 0;
        while ((rf_words - start) < 5 && n < 200) begin
            @(negedge clk); n++;
        end
        chk("midfill_words", rf_words - start, 5);
        rst_n = 1'b0;
        #1;
        chk_reset_vals("midfill");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [31:0] ra;
        rst_n      = 1'b0;
        addr_valid = 1'b0;
        addr_data  = '0;
        order_busy = 1'b0;
        flush_req  = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        #1;
        chk_reset_vals("por");
        rst_n = 1'b1;
        @(negedge clk);

        // cold miss, then hits in the same line
        do_fetch(32'h040, 0);
        do_fetch(32'h048, 0);
        chk("hit_count_after_first_hit", hit_count, 1);
        back_to_back();

        // output backpressure on a hit
        do_fetch(32'h054, 3);
        do_fetch(32'h058, 0);

        // round-robin replacement within set 1
        do_fetch(32'h140, 0);
        do_fetch(32'h240, 0);
        do_fetch(32'h340, 0);
        do_fetch(32'h440, 0);
        do_fetch(32'h140, 0);
        do_fetch(32'h040, 0);
        chk("replacement_miss_count", miss_count, 6);

        // flush, then the line must be refetched from its first word
        do_flush();
        do_fetch(32'h048, 0);

        // randomized traffic with memory-side stalls
        mem_stall_en = 1'b1;
        repeat (30) begin
            if ($urandom_range(0, 7) == 0) do_flush();
            ra = {24'($urandom_range(0, 5)), 2'($urandom_range(0, 3)),
                  4'($urandom_range(0, 15)), 2'b00};
            do_fetch(ra, $urandom_range(0, 2));
        end
        mem_stall_en = 1'b0;
        repeat (3) @(negedge clk);

        // reset in the middle of a refill leaves nothing valid
        reset_mid_fill();
        do_fetch(32'h040, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
